// File: rtl/switch_operand_reader.sv
// Assembles an operand from successive switch bytes, one byte per debounced load-button press.
// Capture lands two cycles after btn_db rises; a held operand waits for op_valid/op_ready.
module switch_operand_reader #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int NUM_BYTES       = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             sw,
  input  logic                   load_btn,
  input  logic                   clear,
  output logic [8*NUM_BYTES-1:0] op_data,
  output logic                   op_valid,
  input  logic                   op_ready,
  output logic [2:0]             byte_idx,
  output logic                   overrun,
  output logic                   btn_db
);

  localparam int DW = 8 * NUM_BYTES;
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0] IDX_LAST = 3'(NUM_BYTES);

  typedef enum logic {COLLECT, FULL} state_t;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_db_q, btn_db_d;
  logic             db_prev_q, db_prev_d;
  logic             press_q, press_d;
  state_t           state_q, state_d;
  logic [DW-1:0]    op_data_q, op_data_d;
  logic [2:0]       byte_idx_q, byte_idx_d;
  logic             overrun_q, overrun_d;
  logic [DW-1:0]    shifted;

  // Front end: synchronizer, debounce counter and rising-edge press pulse.
  always_comb begin
    sync1_d   = load_btn;
    sync2_d   = sync1_q;
    cnt_d     = '0;
    btn_db_d  = btn_db_q;
    db_prev_d = btn_db_q;
    press_d   = btn_db_q & ~db_prev_q;
    if (sync2_q != btn_db_q) begin
      if (cnt_q == CNT_MAX) begin
        btn_db_d = ~btn_db_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Oldest byte migrates toward the MSB as new bytes enter at the bottom.
  assign shifted = DW'({op_data_q, sw});

  always_comb begin
    state_d    = state_q;
    op_data_d  = op_data_q;
    byte_idx_d = byte_idx_q;
    overrun_d  = overrun_q;
    if (clear) begin
      state_d    = COLLECT;
      byte_idx_d = 3'd0;
      overrun_d  = 1'b0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (press_q) begin
            op_data_d  = shifted;
            byte_idx_d = byte_idx_q + 3'd1;
            if (byte_idx_q + 3'd1 == IDX_LAST) begin
              state_d = FULL;
            end
          end
        end
        FULL: begin
          if (op_ready) begin
            state_d    = COLLECT;
            byte_idx_d = 3'd0;
            if (press_q) begin
              op_data_d  = shifted;
              byte_idx_d = 3'd1;
            end
          end else if (press_q) begin
            overrun_d = 1'b1;
          end
        end
        default: state_d = COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      cnt_q      <= '0;
      btn_db_q   <= 1'b0;
      db_prev_q  <= 1'b0;
      press_q    <= 1'b0;
      state_q    <= COLLECT;
      op_data_q  <= '0;
      byte_idx_q <= 3'd0;
      overrun_q  <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      cnt_q      <= cnt_d;
      btn_db_q   <= btn_db_d;
      db_prev_q  <= db_prev_d;
      press_q    <= press_d;
      state_q    <= state_d;
      op_data_q  <= op_data_d;
      byte_idx_q <= byte_idx_d;
      overrun_q  <= overrun_d;
    end
  end

  assign op_data  = op_data_q;
  assign op_valid = (state_q == FULL);
  assign byte_idx = byte_idx_q;
  assign overrun  = overrun_q;
  assign btn_db   = btn_db_q;

endmodule
